hazard_scoreboard: RTL and testbench

//  Consumer-side counterpart to the destination parser. Decodes the source registers
//  (Rs [10:8], Rt [7:5]) of the instruction in decode and tracks in-flight destination

---
 rtl/hazard_scoreboard.sv | 97 +++++++++
 tb/tb_hazard_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard detector for a no-forwarding pipeline: decodes the decode-stage sources and
// tracks in-flight destination writes in a shift-register scoreboard, one entry per stage.
module hazard_scoreboard #(
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_instr,
    input  logic             id_valid,
    input  logic             flush,
    input  logic             freeze,
    output logic             stall,
    output logic [DEPTH-1:0] sb_valid,
    output logic [CNT_W-1:0] stall_cnt
);
    // Entries at index CHK and beyond are covered by the register-file bypass.
    localparam int CHK = DEPTH - RF_BYPASS;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [4:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       dest_valid;
    logic [2:0] dest;
    logic       rs_hit;
    logic       rt_hit;
    logic [2:0] sb_reg [DEPTH];
    logic       unused_lsb;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign op         = id_instr[15:11];
    assign rs         = id_instr[10:8];
    assign rt         = id_instr[7:5];
    assign unused_lsb = ^id_instr[1:0];

    always_comb begin
        rs_used    = 1'b1;
        rt_used    = 1'b0;
        dest_valid = 1'b1;
        dest       = id_instr[4:2];
        casez (op)
            5'b000??: begin rs_used = 1'b0; dest_valid = 1'b0; end
            5'b00100: begin rs_used = 1'b0; dest_valid = 1'b0; end
            5'b00101: dest_valid = 1'b0;
            5'b00110: begin rs_used = 1'b0; dest = 3'd7; end
            5'b00111: dest = 3'd7;
            5'b010??: dest = id_instr[7:5];
            5'b011??: dest_valid = 1'b0;
            5'b10000: begin rt_used = 1'b1; dest_valid = 1'b0; end
            5'b10001: dest = id_instr[7:5];
            5'b10010: dest = id_instr[10:8];
            5'b10011: begin rt_used = 1'b1; dest = id_instr[10:8]; end
            5'b101??: dest = id_instr[7:5];
            5'b11000: begin rs_used = 1'b0; dest = id_instr[10:8]; end
            5'b11001: dest = id_instr[4:2];
            5'b1101?: rt_used = 1'b1;
            5'b111??: rt_used = 1'b1;
            default:  dest_valid = 1'b1;
        endcase
    end

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int k = 0; k < CHK; k++) begin
            if (sb_valid[k] && sb_reg[k] == rs) rs_hit = 1'b1;
            if (sb_valid[k] && sb_reg[k] == rt) rt_hit = 1'b1;
        end
    end

    assign stall = id_valid & ~flush & ~rst & ((rs_used & rs_hit) | (rt_used & rt_hit));

    // Scoreboard shift: a stalled or squashed decode slot enters EX as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid  <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) sb_reg[k] <= '0;
        end else if (!freeze) begin
            for (int k = 1; k < DEPTH; k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_reg[k]   <= sb_reg[k-1];
            end
            sb_valid[0] <= id_valid & dest_valid & ~stall & ~flush;
            sb_reg[0]   <= dest;
            if (stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, multi-cycle sequences, and
// randomized traffic checked against an issue-history model.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, id_valid = 1'b0, flush = 1'b0, freeze = 1'b0;
    logic [15:0] id_instr = '0;
    logic        stall, stall_nb, stall_sat;
    logic [2:0]  sbv, sbv_nb, sbv_sat;
    logic [15:0] cnt, cnt_nb;
    logic [3:0]  cnt_sat;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
        .freeze(freeze), .stall(stall), .sb_valid(sbv), .stall_cnt(cnt));
    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(0), .CNT_W(16)) dut_nb (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
        .freeze(freeze), .stall(stall_nb), .sb_valid(sbv_nb), .stall_cnt(cnt_nb));
    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
        .freeze(freeze), .stall(stall_sat), .sb_valid(sbv_sat), .stall_cnt(cnt_sat));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list of issued writes tagged with the advance count at issue.
    int q0[$];
    int q1[$];
    int adv  = 0;
    int tot0 = 0;
    int tot1 = 0;
    bit es0, es1;

    function automatic bit m_rs_used(input logic [4:0] op);
        return !(op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd24});
    endfunction

    function automatic bit m_rt_used(input logic [4:0] op);
        return (op inside {5'b10000, 5'b10011, 5'b11010, 5'b11011}) || (op[4:2] == 3'b111);
    endfunction

    function automatic int m_dest(input logic [15:0] ins);
        logic [4:0] op;
        op = ins[15:11];
        if (op[4:2] == 3'b000 || op == 5'b00100 || op == 5'b00101 ||
            op[4:2] == 3'b011 || op == 5'b10000) return -1;
        if (op == 5'b00110 || op == 5'b00111) return 7;
        if (op inside {5'b10010, 5'b10011, 5'b11000}) return int'(ins[10:8]);
        if (op[4:2] == 3'b010 || op[4:2] == 3'b101 || op == 5'b10001) return int'(ins[7:5]);
        return int'(ins[4:2]);
    endfunction

    function automatic bit m_blocked(input int q[$], input int win, input logic [2:0] r);
        bit hit;
        hit = 1'b0;
        foreach (q[i]) if ((q[i] % 8) == int'(r) && (adv - q[i] / 8) <= win) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [2:0] m_sbv(input int q[$]);
        logic [2:0] v;
        int age;
        v = '0;
        foreach (q[i]) begin
            age = adv - q[i] / 8;
            if (age >= 1 && age <= 3) v[age-1] = 1'b1;
        end
        return v;
    endfunction

    function automatic bit m_stall(input int q[$], input int win);
        return id_valid && !flush && !rst &&
               ((m_rs_used(id_instr[15:11]) && m_blocked(q, win, id_instr[10:8])) ||
                (m_rt_used(id_instr[15:11]) && m_blocked(q, win, id_instr[7:5])));
    endfunction

    task automatic apply(input logic [15:0] ins, input logic v, fl, fz, r);
        id_instr = ins; id_valid = v; flush = fl; freeze = fz; rst = r;
        @(negedge clk);
        es0 = m_stall(q0, 2);
        es1 = m_stall(q1, 3);
    endtask

    task automatic advance();
        int d;
        @(posedge clk);
        d = m_dest(id_instr);
        if (rst) begin
            q0.delete(); q1.delete(); tot0 = 0; tot1 = 0;
        end else if (!freeze) begin
            if (es0) tot0++;
            if (es1) tot1++;
            if (id_valid && !flush && d >= 0) begin
                if (!es0) q0.push_back(adv * 8 + d);
                if (!es1) q1.push_back(adv * 8 + d);
            end
            adv++;
            while (q0.size() > 0 && adv - q0[0] / 8 > 3) void'(q0.pop_front());
            while (q1.size() > 0 && adv - q1[0] / 8 > 3) void'(q1.pop_front());
        end
        #1;
    endtask

    task automatic check_model();
        check("stall", 32'(stall), 32'(es0));
        check("sb_valid", 32'(sbv), 32'(m_sbv(q0)));
        check("stall_cnt", 32'(cnt), (tot0 > 65535) ? 65535 : tot0);
        check("nb_stall", 32'(stall_nb), 32'(es1));
        check("nb_sb_valid", 32'(sbv_nb), 32'(m_sbv(q1)));
        check("nb_stall_cnt", 32'(cnt_nb), (tot1 > 65535) ? 65535 : tot1);
        check("sat_stall", 32'(stall_sat), 32'(es0));
        check("sat_stall_cnt", 32'(cnt_sat), (tot0 > 15) ? 15 : tot0);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic        v, fl, fz, r, es;
        logic [2:0]  sbv;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [15:0] ins, input logic v, fl, fz, r, es,
                       input logic [2:0] sv, input logic [15:0] c);
        vec_t t;
        t.ins = ins; t.v = v; t.fl = fl; t.fz = fz; t.r = r; t.es = es; t.sbv = sv; t.cnt = c;
        tbl.push_back(t);
    endtask

    localparam logic [15:0] BUB    = 16'h0000;
    localparam logic [15:0] ADDI1  = {5'b01000, 3'd2, 3'd1, 5'd3};
    localparam logic [15:0] ADD31  = {5'b11011, 3'd1, 3'd4, 3'd3, 2'b00};
    localparam logic [15:0] LD25   = {5'b10001, 3'd5, 3'd2, 5'd0};
    localparam logic [15:0] ST26   = {5'b10000, 3'd6, 3'd2, 5'd0};
    localparam logic [15:0] NOP    = {5'b00001, 11'd0};
    localparam logic [15:0] JAL    = {5'b00110, 11'd4};
    localparam logic [15:0] ADD071 = {5'b11011, 3'd7, 3'd1, 3'd0, 2'b00};
    localparam logic [15:0] JMP    = {5'b00100, 11'd8};
    localparam logic [15:0] ADD222 = {5'b11011, 3'd2, 3'd2, 3'd2, 2'b00};
    localparam logic [15:0] BEQZ3  = {5'b01100, 3'd3, 8'd2};
    localparam logic [15:0] ADD033 = {5'b11011, 3'd3, 3'd3, 3'd0, 2'b00};
    localparam logic [15:0] ADDI11 = {5'b01000, 3'd1, 3'd1, 5'd1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_dut, n_nb;
        logic [15:0] ins;

        // Dependent pair ADDI r1 / ADD r3,r1,r4
        add(BUB,    0,0,0,1, 0,3'b000,0);
        add(ADDI1,  1,0,0,0, 0,3'b000,0);
        add(ADD31,  1,0,0,0, 1,3'b001,0);
        add(ADD31,  1,0,0,0, 1,3'b010,1);
        add(ADD31,  1,0,0,0, 0,3'b100,2);
        add(BUB,    0,0,0,0, 0,3'b001,2);
        add(BUB,    0,0,0,0, 0,3'b010,2);
        add(BUB,    0,0,0,0, 0,3'b100,2);
        // LD r2 / ST r2 (Rt hazard), then with an independent NOP between
        add(LD25,   1,0,0,0, 0,3'b000,2);
        add(ST26,   1,0,0,0, 1,3'b001,2);
        add(ST26,   1,0,0,0, 1,3'b010,3);
        add(ST26,   1,0,0,0, 0,3'b100,4);
        add(LD25,   1,0,0,0, 0,3'b000,4);
        add(NOP,    1,0,0,0, 0,3'b001,4);
        add(ST26,   1,0,0,0, 1,3'b010,4);
        add(ST26,   1,0,0,0, 0,3'b100,5);
        // JAL then read of R7
        add(JAL,    1,0,0,0, 0,3'b000,5);
        add(ADD071, 1,0,0,0, 1,3'b001,5);
        add(ADD071, 1,0,0,0, 1,3'b010,6);
        add(ADD071, 1,0,0,0, 0,3'b100,7);
        add(BUB,    0,0,0,0, 0,3'b001,7);
        add(BUB,    0,0,0,0, 0,3'b010,7);
        add(BUB,    0,0,0,0, 0,3'b100,7);
        // J and branch carry no destination
        add(JMP,    1,0,0,0, 0,3'b000,7);
        add(ADD222, 1,0,0,0, 0,3'b000,7);
        add(BUB,    0,0,0,0, 0,3'b001,7);
        add(BUB,    0,0,0,0, 0,3'b010,7);
        add(BUB,    0,0,0,0, 0,3'b100,7);
        add(BEQZ3,  1,0,0,0, 0,3'b000,7);
        add(ADD033, 1,0,0,0, 0,3'b000,7);
        add(BUB,    0,0,0,0, 0,3'b001,7);
        add(BUB,    0,0,0,0, 0,3'b010,7);
        add(BUB,    0,0,0,0, 0,3'b100,7);
        // Freeze for 5 cycles with a dependent consumer waiting
        add(BUB,    0,0,0,1, 0,3'b000,7);
        add(ADDI1,  1,0,0,0, 0,3'b000,0);
        for (int i = 0; i < 5; i++) add(ADD31, 1,0,1,0, 1,3'b001,0);
        add(ADD31,  1,0,0,0, 1,3'b001,0);
        add(ADD31,  1,0,0,0, 1,3'b010,1);
        add(ADD31,  1,0,0,0, 0,3'b100,2);
        add(BUB,    0,0,0,0, 0,3'b001,2);
        add(BUB,    0,0,0,0, 0,3'b010,2);
        add(BUB,    0,0,0,0, 0,3'b100,2);
        // Flush beats a hazard
        add(ADDI1,  1,0,0,0, 0,3'b000,2);
        add(ADD31,  1,1,0,0, 0,3'b001,2);
        add(BUB,    0,0,0,0, 0,3'b010,2);
        add(BUB,    0,0,0,0, 0,3'b100,2);
        // Reset in the middle of a stall
        add(ADDI1,  1,0,0,0, 0,3'b000,2);
        add(ADD31,  1,0,0,0, 1,3'b001,2);
        add(ADD31,  1,0,0,1, 0,3'b010,3);
        add(ADD31,  1,0,0,0, 0,3'b000,0);
        add(BUB,    0,0,0,0, 0,3'b001,0);
        add(BUB,    0,0,0,0, 0,3'b010,0);
        add(BUB,    0,0,0,0, 0,3'b100,0);

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].ins, tbl[i].v, tbl[i].fl, tbl[i].fz, tbl[i].r);
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].es));
            check($sformatf("vec%0d_sb_valid", i), 32'(sbv), 32'(tbl[i].sbv));
            check($sformatf("vec%0d_stall_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
            advance();
        end

        // Without the regfile bypass the same pair stalls one cycle longer
        apply(BUB, 0, 0, 0, 1); advance();
        apply(ADDI1, 1, 0, 0, 0); advance();
        n_dut = 0; n_nb = 0;
        for (int i = 0; i < 6; i++) begin
            apply(ADD31, 1, 0, 0, 0);
            if (stall) n_dut++;
            if (stall_nb) n_nb++;
            advance();
        end
        apply(BUB, 0, 0, 0, 0);
        check("bypass_stall_cycles", 32'(n_dut), 2);
        check("nobypass_stall_cycles", 32'(n_nb), 3);
        check("bypass_cnt", 32'(cnt), 2);
        check("nobypass_cnt", 32'(cnt_nb), 3);
        advance();

        // Self-dependent chain drives the narrow counter into saturation
        apply(BUB, 0, 0, 0, 1); advance();
        for (int i = 0; i < 30; i++) begin
            apply(ADDI11, 1, 0, 0, 0);
            advance();
        end
        apply(BUB, 0, 0, 0, 0);
        check("chain_cnt", 32'(cnt), 20);
        check("chain_nb_cnt", 32'(cnt_nb), 22);
        check("chain_sat_cnt", 32'(cnt_sat), 32'h0000000F);
        advance();

        for (int i = 0; i < 3000; i++) begin
            ins = 16'($urandom);
            ins[10:8] = 3'($urandom_range(0, 3));
            ins[7:5]  = 3'($urandom_range(0, 3));
            ins[4:2]  = 3'($urandom_range(0, 3));
            apply(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
            check_model();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
